// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: rotates a one-hot-low column strobe, assembles a
// 16-bit snapshot per sweep, debounces whole sweeps and reports single-key presses.
module keypad_scan #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEY_CODE,
    output logic       KEY_VALID,
    output logic       KEY_HELD
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned SW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] SLOT_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);

    typedef enum logic {
        IDLE,
        PRESSED
    } state_t;

    logic [DW-1:0] slot_cnt;
    logic [1:0]    col_idx;
    logic [15:0]   partial;
    logic [15:0]   prev_snap;
    logic [SW-1:0] stable_cnt;
    state_t        state;
    state_t        state_next;

    logic          tick;
    logic          sweep_end;
    logic [15:0]   snap;
    logic [SW-1:0] stable_cnt_next;
    logic          snap_stable;
    logic          one_hot;
    logic [3:0]    hot_idx;
    logic [3:0]    code_next;
    logic          valid_next;
    logic          held_next;

    assign tick      = (slot_cnt == SLOT_LAST);
    assign sweep_end = tick && (col_idx == 2'd3);
    assign COL       = ~(4'b0001 << col_idx);

    // The column-3 rows are folded in combinationally so the comparison sees the full sweep.
    assign snap = {~ROW, partial[11:0]};

    always_comb begin
        stable_cnt_next = SW'(1);
        if (snap == prev_snap) begin
            stable_cnt_next = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 1'b1;
        end
    end

    assign snap_stable = (stable_cnt_next == STABLE_MAX);
    assign one_hot     = (snap != '0) && ((snap & (snap - 16'd1)) == '0);

    always_comb begin
        hot_idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (snap[i]) begin
                hot_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            slot_cnt   <= '0;
            col_idx    <= '0;
            partial    <= '0;
            prev_snap  <= '0;
            stable_cnt <= '0;
        end else begin
            slot_cnt <= tick ? '0 : slot_cnt + 1'b1;
            if (tick) begin
                partial[{col_idx, 2'b00} +: 4] <= ~ROW;
                col_idx                        <= col_idx + 2'd1;
            end
            if (sweep_end) begin
                prev_snap  <= snap;
                stable_cnt <= stable_cnt_next;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            KEY_CODE  <= '0;
            KEY_VALID <= 1'b0;
            KEY_HELD  <= 1'b0;
        end else begin
            state     <= state_next;
            KEY_CODE  <= code_next;
            KEY_VALID <= valid_next;
            KEY_HELD  <= held_next;
        end
    end

    always_comb begin
        state_next = state;
        code_next  = KEY_CODE;
        valid_next = 1'b0;
        held_next  = KEY_HELD;
        if (sweep_end && snap_stable) begin
            case (state)
                IDLE: begin
                    if (one_hot) begin
                        code_next  = hot_idx;
                        valid_next = 1'b1;
                        held_next  = 1'b1;
                        state_next = PRESSED;
                    end
                end
                PRESSED: begin
                    if (snap == '0) begin
                        held_next  = 1'b0;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a sweep-history model predicts every output each cycle,
// and literal timing/code expectations pin the scenarios.
module tb_keypad_scan;

    localparam int unsigned SD = 4;
    localparam int unsigned DB = 3;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  ROW;
    logic [3:0]  COL;
    logic [3:0]  KEY_CODE;
    logic        KEY_VALID;
    logic        KEY_HELD;
    logic [15:0] keys;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .CLK(CLK),
        .RST(RST),
        .ROW(ROW),
        .COL(COL),
        .KEY_CODE(KEY_CODE),
        .KEY_VALID(KEY_VALID),
        .KEY_HELD(KEY_HELD)
    );

    // Diode-isolated matrix: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        ROW = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (COL[c] == 1'b0) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[c*4+r]) ROW[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: time since reset decides column and sampling; a sweep is accepted when the
    // last DB sweep snapshots are identical.
    int          m_t;
    logic [15:0] m_part;
    logic [15:0] m_hist[$];
    logic        m_held;
    logic        m_valid;
    logic [3:0]  m_code;
    bit          m_on = 1'b0;
    int          pulse_cnt  = 0;
    int          last_pulse = -1;
    int          fall_t     = -1;
    logic        prev_held  = 1'b0;

    always @(posedge CLK) begin
        int   col;
        bit   same;
        logic [3:0] exp_col;
        if (RST === 1'b1) begin
            m_on   = 1'b1;
            m_t    = 0;
            m_part = '0;
            m_hist.delete();
            m_held  = 1'b0;
            m_valid = 1'b0;
            m_code  = '0;
        end else if (m_on) begin
            col     = (m_t / SD) % 4;
            m_valid = 1'b0;
            if (m_t % SD == SD - 1) begin
                m_part[col*4 +: 4] = keys[col*4 +: 4];
                if (col == 3) begin
                    m_hist.push_back(m_part);
                    if (m_hist.size() > DB) void'(m_hist.pop_front());
                    same = 1'b1;
                    foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) same = 1'b0;
                    if (m_hist.size() == DB && same) begin
                        if (!m_held && $countones(m_part) == 1) begin
                            m_valid = 1'b1;
                            m_held  = 1'b1;
                            for (int i = 0; i < 16; i++) if (m_part[i]) m_code = 4'(i);
                        end else if (m_held && m_part == '0) begin
                            m_held = 1'b0;
                        end
                    end
                end
            end
            m_t++;
        end
        #1;
        if (m_on) begin
            exp_col = ~(4'b0001 << ((m_t / SD) % 4));
            check("model_col", COL, exp_col);
            check("model_valid", KEY_VALID, m_valid);
            check("model_held", KEY_HELD, m_held);
            check("model_code", KEY_CODE, m_code);
            if (KEY_VALID === 1'b1) begin
                pulse_cnt++;
                last_pulse = m_t;
            end
            if (prev_held === 1'b1 && KEY_HELD === 1'b0) fall_t = m_t;
            prev_held = KEY_HELD;
        end
    end

    initial begin
        RST  = 1'b1;
        keys = '0;
        @(negedge CLK);
        check("rst_col", COL, 4'b1110);
        check("rst_code", KEY_CODE, 0);
        check("rst_valid", KEY_VALID, 0);
        check("rst_held", KEY_HELD, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (8) @(negedge CLK);
        check("col_before_midreset", COL, 4'b1011);
        RST = 1'b1;
        @(negedge CLK);
        check("midreset_col", COL, 4'b1110);
        check("midreset_held", KEY_HELD, 0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("col_before_first_tick", COL, 4'b1110);
        @(negedge CLK);
        check("col_after_first_tick", COL, 4'b1101);

        // Single press of code 6 from reset onward
        RST  = 1'b1;
        keys = 16'(1) << 6;
        @(negedge CLK);
        RST = 1'b0;
        repeat (60) @(negedge CLK);
        check("press_pulse_cnt", pulse_cnt, 1);
        check("press_pulse_time", last_pulse, 48);
        check("press_code", KEY_CODE, 6);
        check("press_held", KEY_HELD, 1);

        // Release mid sweep 4; sweeps 5..7 empty
        keys = '0;
        repeat (60) @(negedge CLK);
        check("release_fall_time", fall_t, 112);
        check("release_pulse_cnt", pulse_cnt, 1);
        check("release_code", KEY_CODE, 6);

        // Bounce on code 10 over six sweeps, then steady hold
        repeat (8) @(negedge CLK);
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? (16'(1) << 10) : 16'(0);
            repeat (16) @(negedge CLK);
        end
        check("bounce_no_pulse", pulse_cnt, 1);
        keys = 16'(1) << 10;
        repeat (64) @(negedge CLK);
        check("bounce_pulse_cnt", pulse_cnt, 2);
        check("bounce_pulse_time", last_pulse, 272);
        check("bounce_code", KEY_CODE, 10);

        // Multi-key 0+15, then release 15
        keys = '0;
        repeat (48) @(negedge CLK);
        check("bounce_release_fall", fall_t, 336);
        keys = 16'h8001;
        repeat (80) @(negedge CLK);
        check("multi_no_pulse", pulse_cnt, 2);
        check("multi_held", KEY_HELD, 0);
        keys = 16'h0001;
        repeat (64) @(negedge CLK);
        check("multi_pulse_cnt", pulse_cnt, 3);
        check("multi_pulse_time", last_pulse, 464);
        check("multi_code", KEY_CODE, 0);

        // No rollover: hold 6, add 9, release all, press 9
        keys = '0;
        repeat (48) @(negedge CLK);
        keys = 16'(1) << 6;
        repeat (48) @(negedge CLK);
        keys = (16'(1) << 6) | (16'(1) << 9);
        repeat (80) @(negedge CLK);
        check("rollover_pulse_cnt", pulse_cnt, 4);
        check("rollover_code", KEY_CODE, 6);
        check("rollover_held", KEY_HELD, 1);
        keys = '0;
        repeat (48) @(negedge CLK);
        check("rollover_fall", fall_t, 704);
        keys = 16'(1) << 9;
        repeat (64) @(negedge CLK);
        check("second_pulse_cnt", pulse_cnt, 5);
        check("second_pulse_time", last_pulse, 752);
        check("second_code", KEY_CODE, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 active-low button matrix for the player's control panel (play/pause, next, previous, volume).
- It is the input-side counterpart of the multiplexed 7-segment driver. It drives a rotating one-hot-low column strobe, in the same way the display rotates its digit enables, and reads the row lines back.
- Each full sweep produces a 16-bit snapshot. Snapshots are debounced, and the block emits one key code plus a single-cycle valid pulse per accepted press.

Parameters:
- SCAN_DIV, 50000: CLK cycles per column slot. Must be ≥ 2.
- DEBOUNCE, 4: number of consecutive identical sweep snapshots needed before a state is accepted. Must be ≥ 1.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- ROW  input  4  matrix row sense lines, active-low (0 = pressed). Externally pulled up and already synchronised.
- COL  output  4  column strobes, one-hot active-low.
- KEY_CODE  output  4  code of the accepted key, = col*4 + row.
- KEY_VALID  output  1  one-CLK pulse when a press is accepted.
- KEY_HELD  output  1  high while the accepted key remains pressed.

Behaviour:
- Reset: the following take effect at the first CLK edge with RST=1.
  - Outputs: COL=4'b1110, KEY_CODE=0, KEY_VALID=0, KEY_HELD=0.
  - Internal state: slot counter 0, column index 0, partial snapshot 0, previous snapshot 0, stable count 0, FSM=IDLE.
  - Reset asserted mid-sweep discards the partial snapshot. A new sweep starts at column 0.
- Slot timer:
  - The counter runs 0..SCAN_DIV-1, then wraps.
  - On the cycle the counter equals SCAN_DIV-1 (the tick), ROW is sampled for the active column c. Sampling at slot end gives the lines settle time.
  - For each row r, bit (c*4+r) of the partial snapshot is set to ~ROW[r].
  - On the next edge COL rotates left: 1110 → 1101 → 1011 → 0111 → 1110. The column index increments mod 4.
- Sweep end:
  - The sweep ends on the tick for column 3. Sweep length is 4*SCAN_DIV cycles.
  - The completed snapshot S (including column 3 bits) is compared against the previous snapshot.
  - If S equals the previous snapshot, the stable count increments, saturating at DEBOUNCE. Otherwise the count becomes 1.
  - The previous snapshot is then set to S.
  - S is "stable" on the sweep where the stable count reaches or stays at DEBOUNCE.
- FSM, evaluated only at a sweep end with a stable snapshot:
  - IDLE:
    - If S has exactly one bit set (index k): set KEY_CODE=k, pulse KEY_VALID for one cycle, set KEY_HELD=1, go to PRESSED.
    - If S is all-zero or has two or more bits set (multi-key or ghosting): stay in IDLE with no output.
  - PRESSED:
    - If S is all-zero: set KEY_HELD=0 and go to IDLE. KEY_CODE holds its last value.
    - Any other stable pattern (second key added, or a different key): stay in PRESSED with no new pulse. The block has no rollover; a new event requires a full release first.
- Latency:
  - KEY_VALID rises in the cycle after the sweep-end tick of the DEBOUNCE-th identical sweep.
  - When a press is present throughout, this is DEBOUNCE*4*SCAN_DIV cycles after the start of the first full sweep containing it.
- Boundaries:
  - A press that starts mid-sweep yields a partial first snapshot. That snapshot counts as a different pattern, so it delays acceptance by one sweep.
  - Bounce resets the stable count to 1.
  - KEY_VALID is never high for two consecutive cycles.
  - KEY_VALID and the KEY_HELD fall cannot occur on the same edge.
  - The stable count saturates, so a held key never re-triggers.

Test Plan:
- Reset mid-sweep (SCAN_DIV=4, DEBOUNCE=3): assert RST for 1 cycle when COL=1011 → next cycle COL=1110 with all outputs 0. The first tick occurs 4 cycles after RST is released.
- Single press: hold ROW[2]=0 only while COL=1101 (col 1), from reset onward → exactly one KEY_VALID pulse with KEY_CODE=6. The pulse occurs on the cycle after the end of sweep 3 (about cycle 48). KEY_HELD=1 after that.
- Release: from the PRESSED state of the single-press case, release the key → KEY_HELD drops after 3 identical empty sweeps (48 cycles after the first empty sweep), with no KEY_VALID. KEY_CODE stays 6.
- Bounce: toggle the press on alternate sweeps for 6 sweeps, then hold it → no pulse during the toggling. The pulse comes 3 sweeps after the steady hold begins.
- Multi-key: press codes 0 and 15 together for 5 sweeps → no KEY_VALID, KEY_HELD=0. Then release code 15 → a pulse with KEY_CODE=0 after 3 sweeps.
- No rollover: in PRESSED with code 6, add code 9 for 5 sweeps → no new pulse. Release all for 3 sweeps, then press code 9 → a pulse with KEY_CODE=9.
